// File: rtl/semaforo_pedestre.sv
// Pedestrian request conditioner: synchronizes and debounces the push button, latches the
// request and presents it as the controller's bt input aligned to light-A cycle boundaries.
module semaforo_pedestre #(
   parameter int DEB_CYCLES   = 4,
   parameter int SERVE_CYCLES = 1,
   parameter int COOL_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_raw,
   input  logic [2:0] luz_a,
   output logic       bt,
   output logic       pend,
   output logic       atendido
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PEND,
      ST_SERVE,
      ST_COOL
   } state_t;

   localparam logic [7:0] DEB_LAST   = 8'(DEB_CYCLES - 1);
   localparam logic [3:0] SERVE_LAST = 4'(SERVE_CYCLES);
   localparam logic [3:0] COOL_LAST  = 4'(COOL_CYCLES);
   localparam logic [2:0] LUZ_GREEN  = 3'b001;

   logic       r_sync1;
   logic       r_sync2;
   logic       r_deb;
   logic [7:0] r_debCnt;
   logic [2:0] r_luzPrev;
   state_t     r_state;
   logic [3:0] r_cyc;
   logic       r_guard;
   logic       r_bt;
   logic       r_pend;
   logic       r_atend;

   state_t     w_stateNext;
   logic [3:0] w_cycNext;
   logic [3:0] w_cycInc;
   logic       w_guardNext;
   logic       w_atendNext;
   logic       w_debAccept;
   logic       w_press;
   logic       w_a0Ent;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   // A new level is accepted on the edge of its DEB_CYCLES-th consecutive differing sample;
   // the press pulse coincides with that acceptance edge.
   assign w_debAccept = (r_sync2 != r_deb) && (r_debCnt >= DEB_LAST);
   assign w_press     = w_debAccept && r_sync2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_deb    <= 1'b0;
         r_debCnt <= 8'd0;
      end else if (r_sync2 == r_deb) begin
         r_debCnt <= 8'd0;
      end else if (w_debAccept) begin
         r_deb    <= r_sync2;
         r_debCnt <= 8'd0;
      end else if (r_debCnt != 8'hFF) begin
         r_debCnt <= r_debCnt + 8'd1;
      end
   end

   assign w_a0Ent  = (luz_a == LUZ_GREEN) && (r_luzPrev != LUZ_GREEN);
   assign w_cycInc = (r_cyc == 4'hF) ? r_cyc : r_cyc + 4'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_luzPrev <= LUZ_GREEN;
         r_state   <= ST_IDLE;
         r_cyc     <= 4'd0;
         r_guard   <= 1'b0;
         r_bt      <= 1'b0;
         r_pend    <= 1'b0;
         r_atend   <= 1'b0;
      end else begin
         r_luzPrev <= luz_a;
         r_state   <= w_stateNext;
         r_cyc     <= w_cycNext;
         r_guard   <= w_guardNext;
         r_bt      <= (w_stateNext == ST_SERVE);
         r_pend    <= (w_stateNext == ST_PEND) || ((w_stateNext == ST_COOL) && w_guardNext);
         r_atend   <= w_atendNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_cycNext   = r_cyc;
      w_guardNext = r_guard;
      w_atendNext = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_press) begin
               w_stateNext = ST_PEND;
            end
         end
         ST_PEND: begin
            if (w_a0Ent) begin
               w_stateNext = ST_SERVE;
               w_cycNext   = 4'd0;
            end
         end
         ST_SERVE: begin
            if (w_a0Ent) begin
               w_cycNext = w_cycInc;
               if (w_cycInc >= SERVE_LAST) begin
                  w_atendNext = 1'b1;
                  w_cycNext   = 4'd0;
                  w_guardNext = 1'b0;
                  w_stateNext = (COOL_CYCLES == 0) ? ST_IDLE : ST_COOL;
               end
            end
         end
         ST_COOL: begin
            // A press that lands on the closing boundary still counts toward the guard.
            w_guardNext = r_guard | w_press;
            if (w_a0Ent) begin
               w_cycNext = w_cycInc;
               if (w_cycInc >= COOL_LAST) begin
                  w_stateNext = w_guardNext ? ST_PEND : ST_IDLE;
                  w_guardNext = 1'b0;
                  w_cycNext   = 4'd0;
               end
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   assign bt       = r_bt;
   assign pend     = r_pend;
   assign atendido = r_atend;

endmodule

// File: tb/tb_semaforo_pedestre.sv
// Self-checking bench for semaforo_pedestre: directed light cycles with per-clock expectations
// queued at drive time; a second instance covers the zero-cooldown configuration.
module tb_semaforo_pedestre;

   typedef struct {
      int bt;
      int pend;
      int at;
      int bt0;
      int pend0;
      int at0;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_raw;
   logic [2:0] luz_a;
   logic       bt, pend, atendido;
   logic       bt0, pend0, atendido0;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;

   semaforo_pedestre #(.DEB_CYCLES(4), .SERVE_CYCLES(1), .COOL_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .luz_a(luz_a),
      .bt(bt), .pend(pend), .atendido(atendido)
   );

   semaforo_pedestre #(.DEB_CYCLES(4), .SERVE_CYCLES(1), .COOL_CYCLES(0)) dutNoCool (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .luz_a(luz_a),
      .bt(bt0), .pend(pend0), .atendido(atendido0)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input int eBt, input int ePend, input int eAt,
                               input int zBt, input int zPend, input int zAt);
      exp_t e;
      e.bt    = eBt;
      e.pend  = ePend;
      e.at    = eAt;
      e.bt0   = zBt;
      e.pend0 = zPend;
      e.at0   = zAt;
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic obs, input logic expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %b expected %b", tag, $time, obs, expv);
      end
   endtask

   // Drives one clock of inputs at the falling edge, queues what the outputs must show after
   // the following rising edge, then pops and compares; -1 marks a field left unchecked.
   task automatic applyStimulus(input string tag, input logic b, input logic [2:0] l, input exp_t e);
      exp_t got;
      @(negedge clk);
      btn_raw = b;
      luz_a   = l;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      if (got.bt    >= 0) checkOutput({tag, " bt"},        bt,        got.bt[0]);
      if (got.pend  >= 0) checkOutput({tag, " pend"},      pend,      got.pend[0]);
      if (got.at    >= 0) checkOutput({tag, " atendido"},  atendido,  got.at[0]);
      if (got.bt0   >= 0) checkOutput({tag, " bt0"},       bt0,       got.bt0[0]);
      if (got.pend0 >= 0) checkOutput({tag, " pend0"},     pend0,     got.pend0[0]);
      if (got.at0   >= 0) checkOutput({tag, " atendido0"}, atendido0, got.at0[0]);
   endtask

   // One 9-clock light cycle: first colour x2, yellow x4, red x3; expectations after call 0
   // reflect the boundary edge, pend may switch from ePendA to ePendB at call pendSw.
   task automatic lightCycle(input string tag, input logic [2:0] first, input logic [8:0] btnMask,
                             input int eBt, input int ePendA, input int ePendB, input int pendSw,
                             input int eAt, input int zBt, input int zAt);
      logic [2:0] seq;
      for (int i = 0; i < 9; i++) begin
         seq = (i < 2) ? first : ((i < 6) ? 3'b010 : 3'b100);
         applyStimulus(tag, btnMask[i], seq,
                       mk(eBt, (i < pendSw) ? ePendA : ePendB, (i == 0) ? eAt : 0,
                          (i == 0) ? zBt : -1, -1, (i == 0) ? zAt : -1));
      end
   endtask

   initial begin
      rst     = 1'b0;
      btn_raw = 1'b1;
      luz_a   = 3'b001;

      applyStimulus("reset", 1'b1, 3'b001, mk(0, 0, 0, 0, 0, 0));
      applyStimulus("reset", 1'b1, 3'b010, mk(0, 0, 0, 0, 0, 0));
      applyStimulus("reset", 1'b1, 3'b100, mk(0, 0, 0, 0, 0, 0));
      applyStimulus("reset", 1'b1, 3'b001, mk(0, 0, 0, 0, 0, 0));
      btn_raw = 1'b0;
      luz_a   = 3'b100;
      #2 rst  = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus("postReset", 1'b0, 3'b100, mk(0, 0, 0, 0, 0, 0));

      for (int g = 0; g < 5; g++)
         for (int i = 0; i < 8; i++) applyStimulus("glitch", (i < 3), 3'b100, mk(0, 0, 0, -1, -1, -1));

      for (int i = 0; i < 8; i++)
         applyStimulus("debounce", 1'b1, 3'b100, mk(0, (i >= 5) ? 1 : 0, 0, -1, -1, -1));
      for (int i = 0; i < 8; i++) applyStimulus("latched", 1'b0, 3'b100, mk(0, 1, 0, -1, -1, -1));

      lightCycle("serve",     3'b001, 9'b000000000, 1, 0, 0, 9, 0, 1, 0);
      lightCycle("coolPress", 3'b001, 9'b011111111, 0, 0, 1, 5, 1, 0, 1);
      lightCycle("cool",      3'b001, 9'b000000000, 0, 1, 1, 0, 0, 1, 0);
      lightCycle("coolEnd",   3'b001, 9'b000000000, 0, 1, 1, 0, 0, 0, 1);
      lightCycle("serve2",    3'b001, 9'b000000000, 1, 0, 0, 0, 0, -1, -1);
      lightCycle("cool2",     3'b001, 9'b000000000, 0, 0, 0, 0, 1, -1, -1);
      lightCycle("cool2b",    3'b001, 9'b000000000, 0, 0, 0, 0, 0, -1, -1);
      lightCycle("idle",      3'b001, 9'b000000000, 0, 0, 0, 0, 0, -1, -1);

      lightCycle("preCoinc",  3'b001, 9'b111110000, 0, 0, 0, 0, 0, -1, -1);
      lightCycle("coinc",     3'b001, 9'b000000111, 0, 1, 1, 0, 0, -1, -1);
      lightCycle("coincSrv",  3'b001, 9'b000000000, 1, 0, 0, 0, 0, -1, -1);
      lightCycle("coincCool", 3'b001, 9'b000000000, 0, 0, 0, 0, 1, -1, -1);
      lightCycle("coincCl2",  3'b001, 9'b000000000, 0, 0, 0, 0, 0, -1, -1);
      lightCycle("coincIdle", 3'b001, 9'b000000000, 0, 0, 0, 0, 0, -1, -1);

      for (int i = 0; i < 8; i++)
         applyStimulus("press3", 1'b1, 3'b100, mk(0, (i >= 5) ? 1 : 0, 0, -1, -1, -1));
      for (int i = 0; i < 8; i++) applyStimulus("hold3", 1'b0, 3'b100, mk(0, 1, 0, -1, -1, -1));
      lightCycle("badLuz", 3'b011, 9'b000000000, 0, 1, 1, 0, 0, -1, -1);
      applyStimulus("serve3", 1'b0, 3'b001, mk(1, 0, 0, -1, -1, -1));
      applyStimulus("serve3", 1'b0, 3'b001, mk(1, 0, 0, -1, -1, -1));
      applyStimulus("serve3", 1'b0, 3'b010, mk(1, 0, 0, -1, -1, -1));

      // Reset lands between edges; bt must clear without waiting for a clock.
      rst = 1'b0;
      #2;
      checkOutput("asyncRst bt", bt, 1'b0);
      checkOutput("asyncRst pend", pend, 1'b0);
      checkOutput("asyncRst atendido", atendido, 1'b0);
      #1 rst = 1'b1;
      lightCycle("lost",  3'b001, 9'b000000000, 0, 0, 0, 0, 0, -1, -1);
      lightCycle("lost2", 3'b001, 9'b000000000, 0, 0, 0, 0, 0, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/semaforo_pedestre.md
Name: semaforo_pedestre

Overview:
- Pedestrian request conditioner directly upstream of the traffic-light controller; produces that controller's `bt` input.
- Synchronizes and debounces the raw push button, then latches a pending request.
- Asserts `bt` aligned to the start of a light cycle, holds it for a fixed number of full cycles, then enforces a cooldown.
- Monitors the controller's one-hot light A output to find cycle boundaries.

Parameters:
- DEB_CYCLES, 4: consecutive stable synced samples required to accept a button level change (1..255).
- SERVE_CYCLES, 1: full light cycles (A0 entries) for which `bt` stays high (1..15).
- COOL_CYCLES, 2: full light cycles after service during which no new service starts (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- btn_raw  in  1  raw pedestrian push button, asynchronous, bouncy.
- luz_a  in  3  controller light A, one-hot (001 green, 010 yellow, 100 red).
- bt  out  1  service request to the controller, registered.
- pend  out  1  "wait" lamp: a request is latched and not yet served, registered.
- atendido  out  1  one-clock pulse when a service window ends, registered.

Behaviour:
- Reset (rst=0, async): all state cleared; bt=0, pend=0, atendido=0; FSM=IDLE; sync flops=0; debounced level=0; luz_a_prev=001.
- Sync: btn_raw passes through 2 flops (btn_s).
- Debounce:
  - An 8-bit counter increments while btn_s != deb and clears when btn_s == deb.
  - When the count reaches DEB_CYCLES-1 with btn_s still != deb, deb takes btn_s on that edge and the counter clears.
  - press = deb rising edge, 1 clock wide.
- Cycle boundary:
  - a0_ent = (luz_a==001) && (luz_a_prev!=001).
  - luz_a_prev is registered every clock.
  - Non-one-hot luz_a never produces a0_ent.
- FSM (4 states):
  - IDLE: bt=0, pend=0. On press -> PEND.
  - PEND: pend=1, bt=0. On a0_ent -> SERVE; the cycle counter loads 0.
  - SERVE: bt=1, pend=0.
    - On a0_ent the cycle counter increments.
    - When it reaches SERVE_CYCLES: go to COOL, or to IDLE if COOL_CYCLES==0; assert atendido for 1 clock.
    - Presses in SERVE are ignored.
  - COOL: bt=0; the cycle counter counts a0_ent.
    - A press sets flag guard; pend = guard.
    - After COOL_CYCLES a0_ent: go to PEND if guard (guard clears), else IDLE.
- Timing:
  - All outputs are registered.
  - bt rises the clock after the edge where a0_ent is first seen in PEND.
  - bt falls on the clock after the terminating a0_ent.
- Simultaneous events:
  - press and a0_ent together in IDLE -> PEND only. Service waits for the next a0_ent.
  - press in PEND: no effect, since the request is already latched.
- Counters saturate and never wrap; the 4-bit cycle counter is adequate for the parameter ranges.
- Reset mid-SERVE: bt drops immediately (async) and the pending request is lost.

Test Plan:
- Reset: hold rst=0 with btn_raw=1 and luz_a toggling -> bt=0, pend=0, atendido=0 throughout. After release, wait 3 clocks -> still IDLE.
- Debounce: DEB_CYCLES=4, btn_raw glitches high for 3 clocks x5 -> pend stays 0. Then btn_raw held high for 8 clocks -> pend=1 exactly 2 (sync) + 4 clocks after the rising input.
- Service alignment: pend=1; drive luz_a 9-clock sequence 001x2, 010x4, 100x3 -> bt=1 from the 2nd clock of the next 001 phase, for exactly 9 clocks (SERVE_CYCLES=1). atendido pulses once; pend=0 while bt=1.
- Cooldown: COOL_CYCLES=2; press during COOL -> pend=1, bt stays 0 for 2 cycles (18 clocks), then PEND; bt rises at the following A0 entry.
- Edge cases:
  - press coincident with a0_ent in IDLE -> bt waits one full cycle.
  - luz_a=011 injected -> no service start.
  - COOL_CYCLES=0 -> direct SERVE->IDLE.
- Async reset mid-SERVE: rst=0 between clock edges -> bt=0 immediately, before the next clk edge.
